wb_master_arbiter: RTL and testbench

- Shares one pipelined Wishbone slave port (32-bit data, 4-bit sel) between NUM_MASTERS bus masters, e.g. wbcon_exec and a future DMA/streaming engine, in front of the register/memory fabric.
- Round-robin arbitration with a registered grant held for the whole bus cycle, from CYC rise to CYC fall.
- Master buses are packed; master k occupies slice k of every vector.

---
 rtl/wb_pkg.sv | 18 +
 rtl/rr_pick.sv | 40 ++++
 rtl/wb_master_arbiter.sv | 114 +++++++++++
 tb/tb_wb_master_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the bus arbiters and the register/memory fabric.
package wb_pkg;

   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_SEL_WIDTH  = 4;

   // Arbiter grant state
   typedef enum logic {
      ARB_IDLE    = 1'b0,
      ARB_GRANTED = 1'b1
   } arb_state_t;

   // LSB position of master k's field inside a packed per-master vector of w-bit fields.
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection, purely combinational.
// The request vector is doubled so the search that starts just after the last
// winner can run off the end and wrap without a modulo adder.
module rr_pick #(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_last_idx,
   output logic                   o_any,
   output logic [IDX_W-1:0]       o_idx
);

   logic [2*NUM_MASTERS-1:0] w_req2;
   logic [2*NUM_MASTERS-1:0] w_mask;
   logic [2*NUM_MASTERS-1:0] w_masked;

   assign w_req2   = {i_req, i_req};
   assign w_masked = w_req2 & w_mask;
   assign o_any    = |i_req;

   // Hide every slot up to and including the last winner in the low copy
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < 2*NUM_MASTERS; i++) begin
         w_mask[i] = (i > int'(i_last_idx));
      end
   end

   // Lowest surviving bit is the next requester in round-robin order
   always_comb begin
      o_idx = '0;
      for (int i = 2*NUM_MASTERS-1; i >= 0; i--) begin
         if (w_masked[i]) begin
            o_idx = IDX_W'(i % NUM_MASTERS);
         end
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave port between masters.
// The grant is registered and held from CYC rise to CYC fall of the owner;
// everything on the slave side is a combinational mux from the granted master.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ARB_IDLE    | no owner; slave CYC low, every master stalled
//   ARB_GRANTED | master r_gnt_idx owns the bus until it drops its CYC
module wb_master_arbiter
   import wb_pkg::*;
#(
   parameter  int NUM_MASTERS   = 2,
   parameter  int WB_ADDR_WIDTH = 6,
   localparam int GNT_WIDTH     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NUM_MASTERS-1:0]               i_m_cyc,
   input  logic [NUM_MASTERS-1:0]               i_m_stb,
   input  logic [NUM_MASTERS-1:0]               i_m_we,
   input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] i_m_addr,
   input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] i_m_data,
   input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]  i_m_sel,
   output logic [NUM_MASTERS-1:0]               o_m_stall,
   output logic [NUM_MASTERS-1:0]               o_m_ack,
   output logic [WB_DATA_WIDTH-1:0]             o_m_data,
   output logic                                 o_s_cyc,
   output logic                                 o_s_stb,
   output logic                                 o_s_we,
   output logic [WB_ADDR_WIDTH-1:0]             o_s_addr,
   output logic [WB_DATA_WIDTH-1:0]             o_s_data,
   output logic [WB_SEL_WIDTH-1:0]              o_s_sel,
   input  logic                                 i_s_stall,
   input  logic                                 i_s_ack,
   input  logic [WB_DATA_WIDTH-1:0]             i_s_data,
   output logic                                 o_gnt_valid,
   output logic [GNT_WIDTH-1:0]                 o_gnt_idx
);

   arb_state_t           r_state;
   arb_state_t           w_state_nxt;
   logic [GNT_WIDTH-1:0] r_gnt_idx;
   logic [GNT_WIDTH-1:0] w_gnt_idx_nxt;
   logic [GNT_WIDTH-1:0] r_last_idx;
   logic [GNT_WIDTH-1:0] w_last_idx_nxt;
   logic                 w_pick_any;
   logic [GNT_WIDTH-1:0] w_pick_idx;
   logic                 w_own_cyc;

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .i_req      (i_m_cyc),
      .i_last_idx (r_last_idx),
      .o_any      (w_pick_any),
      .o_idx      (w_pick_idx)
   );

   assign w_own_cyc = i_m_cyc[r_gnt_idx];

   // Grant state register; last_idx starts at the top so master 0 wins first
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ARB_IDLE;
         r_gnt_idx  <= '0;
         r_last_idx <= GNT_WIDTH'(NUM_MASTERS - 1);
      end else begin
         r_state    <= w_state_nxt;
         r_gnt_idx  <= w_gnt_idx_nxt;
         r_last_idx <= w_last_idx_nxt;
      end
   end

   // Arbitrate when idle or on the owner's release edge; the released master
   // is last in the scan order, so it only wins again when nobody else asks
   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_idx_nxt  = r_gnt_idx;
      w_last_idx_nxt = r_last_idx;
      if ((r_state == ARB_IDLE) || !w_own_cyc) begin
         if (w_pick_any) begin
            w_state_nxt    = ARB_GRANTED;
            w_gnt_idx_nxt  = w_pick_idx;
            w_last_idx_nxt = w_pick_idx;
         end else begin
            w_state_nxt = ARB_IDLE;
         end
      end
   end

   // Slave-side mux and master-side steering; ACK is gated by the owner's CYC
   // so acknowledges arriving after an abort never reach any master
   always_comb begin
      o_s_we    = i_m_we[r_gnt_idx];
      o_s_addr  = i_m_addr[slice_lo(int'(r_gnt_idx), WB_ADDR_WIDTH) +: WB_ADDR_WIDTH];
      o_s_data  = i_m_data[slice_lo(int'(r_gnt_idx), WB_DATA_WIDTH) +: WB_DATA_WIDTH];
      o_s_sel   = i_m_sel[slice_lo(int'(r_gnt_idx), WB_SEL_WIDTH) +: WB_SEL_WIDTH];
      o_s_cyc   = 1'b0;
      o_s_stb   = 1'b0;
      o_m_stall = '1;
      o_m_ack   = '0;
      if (r_state == ARB_GRANTED) begin
         o_s_cyc              = w_own_cyc;
         o_s_stb              = w_own_cyc & i_m_stb[r_gnt_idx];
         o_m_stall[r_gnt_idx] = i_s_stall;
         o_m_ack[r_gnt_idx]   = i_s_ack & w_own_cyc;
      end
   end

   assign o_m_data    = i_s_data;
   assign o_gnt_valid = (r_state == ARB_GRANTED);
   assign o_gnt_idx   = r_gnt_idx;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter with two masters: a cycle-by-cycle vector table
// for grant/steering behaviour, then hand sequences against a small delayed
// memory slave for bursts, wait states, abort and asynchronous reset.
module tb_wb_master_arbiter;

   localparam int N  = 2;
   localparam int AW = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    m_cyc, m_stb, m_we;
   logic [N*AW-1:0] m_addr;
   logic [N*32-1:0] m_data;
   logic [N*4-1:0]  m_sel;
   logic [N-1:0]    m_stall, m_ack;
   logic [31:0]     m_rdata;
   logic            s_cyc, s_stb, s_we;
   logic [AW-1:0]   s_addr;
   logic [31:0]     s_dout;
   logic [3:0]      s_sel;
   logic            s_stall, s_ack;
   logic [31:0]     s_din;
   logic            gv;
   logic [0:0]      gi;

   // slave model controls
   logic            use_mem;
   logic            tb_stall, tb_ack;
   logic [31:0]     tb_sdata;
   logic            mem_ack;
   logic [31:0]     mem_rdata;
   int              stall_ws, ack_ws;
   int              stall_cnt = 0;
   int              tcyc = 0;
   logic [31:0]     mem [64];
   int              q_due[$];
   logic [31:0]     q_dat[$];

   int              nvec = 0;
   int              nbad = 0;
   logic [31:0]     wdat [16];
   logic [31:0]     rd_buf [16];

   wb_master_arbiter #(.NUM_MASTERS(N), .WB_ADDR_WIDTH(AW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
      .i_m_addr(m_addr), .i_m_data(m_data), .i_m_sel(m_sel),
      .o_m_stall(m_stall), .o_m_ack(m_ack), .o_m_data(m_rdata),
      .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
      .o_s_addr(s_addr), .o_s_data(s_dout), .o_s_sel(s_sel),
      .i_s_stall(s_stall), .i_s_ack(s_ack), .i_s_data(s_din),
      .o_gnt_valid(gv), .o_gnt_idx(gi)
   );

   always #5 clk = ~clk;

   assign s_stall = use_mem ? (s_cyc && s_stb && (stall_cnt < stall_ws)) : tb_stall;
   assign s_ack   = use_mem ? (mem_ack | tb_ack) : tb_ack;
   assign s_din   = use_mem ? mem_rdata : tb_sdata;

   // Pipelined memory slave: STALL_WS stall cycles per request, ACK ACK_WS
   // cycles after acceptance; a low CYC aborts and flushes pending acks
   always @(posedge clk) begin
      tcyc    <= tcyc + 1;
      mem_ack <= 1'b0;
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
         stall_cnt <= 0;
         q_due.delete();
         q_dat.delete();
      end else if (!use_mem || !s_cyc) begin
         stall_cnt <= 0;
         q_due.delete();
         q_dat.delete();
      end else begin
         if (s_stb) begin
            if (stall_cnt < stall_ws) begin
               stall_cnt <= stall_cnt + 1;
            end else begin
               stall_cnt <= 0;
               if (s_we) mem[s_addr] <= s_dout;
               q_due.push_back(tcyc + ack_ws);
               q_dat.push_back(s_we ? 32'h0 : mem[s_addr]);
            end
         end
         if (q_due.size() > 0 && q_due[0] <= tcyc) begin
            mem_ack   <= 1'b1;
            mem_rdata <= q_dat[0];
            q_due.pop_front();
            q_dat.pop_front();
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // One master runs an n-word pipelined burst; also watches the other master
   task automatic burst(input int m, input bit we, input int a0, input int n,
                        output int nack, output int side_err, output int nst);
      int issued = 0;
      int t      = 0;
      int o      = 1 - m;
      bit acc;
      nack = 0; side_err = 0; nst = 0;
      m_cyc[m] = 1'b1;
      m_stb[m] = 1'b1;
      m_we[m]  = we;
      m_addr[m*AW +: AW] = AW'(a0);
      m_data[m*32 +: 32] = wdat[0];
      while (nack < n && t < 400) begin
         @(negedge clk);
         acc = m_stb[m] && !m_stall[m];
         if (m_ack[m]) begin
            rd_buf[nack] = m_rdata;
            nack++;
         end
         if (m_stall[o] !== 1'b1 || m_ack[o] !== 1'b0) side_err++;
         if (m_stb[m] && m_stall[m] && gv && (int'(gi) == m)) nst++;
         @(posedge clk); #1;
         t++;
         if (acc) begin
            issued++;
            if (issued == n) begin
               m_stb[m] = 1'b0;
            end else begin
               m_addr[m*AW +: AW] = AW'(a0 + issued);
               m_data[m*32 +: 32] = wdat[issued];
            end
         end
      end
      m_cyc[m] = 1'b0;
      m_stb[m] = 1'b0;
   endtask

   typedef struct {
      logic [1:0] cyc;
      logic [1:0] stb;
      logic       sst;
      logic       sack;
      logic [7:0] exp;   // {s_cyc, s_stb, stall[1:0], ack[1:0], gnt_valid, gnt_idx}
   } vec_t;

   vec_t vt [15];

   initial begin
      int nack, side_err, nst, issued, t;
      bit acc, got, ok, any_ack;
      logic [42:0] mux0, mux1;

      vt[0]  = '{2'b11, 2'b11, 1'b0, 1'b0, 8'b0_0_11_00_0_0};
      vt[1]  = '{2'b11, 2'b11, 1'b1, 1'b0, 8'b1_1_11_00_1_0};
      vt[2]  = '{2'b11, 2'b01, 1'b0, 1'b1, 8'b1_1_10_01_1_0};
      vt[3]  = '{2'b10, 2'b00, 1'b0, 1'b1, 8'b0_0_10_00_1_0};
      vt[4]  = '{2'b11, 2'b10, 1'b0, 1'b0, 8'b1_1_01_00_1_1};
      vt[5]  = '{2'b11, 2'b10, 1'b0, 1'b1, 8'b1_1_01_10_1_1};
      vt[6]  = '{2'b01, 2'b00, 1'b1, 1'b0, 8'b0_0_11_00_1_1};
      vt[7]  = '{2'b11, 2'b01, 1'b0, 1'b0, 8'b1_1_10_00_1_0};
      vt[8]  = '{2'b10, 2'b00, 1'b0, 1'b0, 8'b0_0_10_00_1_0};
      vt[9]  = '{2'b00, 2'b00, 1'b0, 1'b0, 8'b0_0_01_00_1_1};
      vt[10] = '{2'b00, 2'b00, 1'b0, 1'b1, 8'b0_0_11_00_0_1};
      vt[11] = '{2'b10, 2'b00, 1'b0, 1'b0, 8'b0_0_11_00_0_1};
      vt[12] = '{2'b10, 2'b10, 1'b0, 1'b0, 8'b1_1_01_00_1_1};
      vt[13] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'b0_0_01_00_1_1};
      vt[14] = '{2'b00, 2'b00, 1'b0, 1'b0, 8'b0_0_11_00_0_1};

      for (int i = 0; i < 16; i++) wdat[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0203;

      m_cyc = '0; m_stb = '0; m_we = 2'b01;
      m_addr = {6'h2A, 6'h15};
      m_data = {32'h2222_FFFF, 32'h1111_0000};
      m_sel  = {4'hC, 4'h3};
      mux0 = {1'b1, 4'h3, 6'h15, 32'h1111_0000};
      mux1 = {1'b0, 4'hC, 6'h2A, 32'h2222_FFFF};
      use_mem = 1'b0; tb_stall = 1'b0; tb_ack = 1'b0; tb_sdata = '0;
      stall_ws = 0; ack_ws = 0;

      // reset state
      #12;
      check("reset_outputs", {s_cyc, s_stb, m_stall, m_ack, gv, s_we, s_sel, s_addr, s_dout},
            {1'b0, 1'b0, 2'b11, 2'b00, 1'b0, mux0});
      @(negedge clk);
      rst = 1'b0;

      // table: grant latency, contention, round robin, release gap, ack discard
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         m_cyc = vt[i].cyc; m_stb = vt[i].stb;
         tb_stall = vt[i].sst; tb_ack = vt[i].sack;
         tb_sdata = 32'hA000_0000 + 32'(i);
         @(negedge clk);
         check($sformatf("vec%0d_ctrl", i), {s_cyc, s_stb, m_stall, m_ack, gv, gi}, vt[i].exp);
         check($sformatf("vec%0d_mux", i), {s_we, s_sel, s_addr, s_dout, m_rdata},
               {(vt[i].exp[0] ? mux1 : mux0), 32'hA000_0000 + 32'(i)});
      end
      @(posedge clk); #1;
      m_cyc = '0; m_stb = '0; tb_ack = 1'b0; tb_stall = 1'b0;
      use_mem = 1'b1;
      @(posedge clk); #1;

      // single master write of 4 words then readback, no wait states
      m_cyc[0] = 1'b1;
      @(negedge clk);
      check("latency_before_grant", {s_cyc, m_stall[0]}, 2'b01);
      @(posedge clk); #1;
      @(negedge clk);
      check("latency_after_grant", {s_cyc, gv, gi}, 3'b1_1_0);
      burst(0, 1'b1, 3, 4, nack, side_err, nst);
      check("wr_acks", 64'(nack), 64'd4);
      check("wr_other_quiet", 64'(side_err), 64'd0);
      check("wr_no_stall", 64'(nst), 64'd0);
      @(posedge clk); #1;
      burst(0, 1'b0, 3, 4, nack, side_err, nst);
      check("rd_acks", 64'(nack), 64'd4);
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (rd_buf[i] !== wdat[i]) ok = 1'b0;
      check("rd_data", 64'(ok), 64'd1);
      check("rd_other_quiet", 64'(side_err), 64'd0);
      @(posedge clk); #1;

      // master 1 reads 16 words with stall and ack wait states
      stall_ws = 2; ack_ws = 3;
      burst(1, 1'b0, 0, 16, nack, side_err, nst);
      check("ws_acks", 64'(nack), 64'd16);
      check("ws_m0_quiet", 64'(side_err), 64'd0);
      check("ws_stall_cycles", 64'(nst), 64'd32);
      ok = 1'b1;
      for (int i = 0; i < 16; i++)
         if (rd_buf[i] !== ((i >= 3 && i <= 6) ? wdat[i-3] : 32'hC0DE_0000 + 32'(i))) ok = 1'b0;
      check("ws_data", 64'(ok), 64'd1);
      @(posedge clk); #1;

      // abort: master 0 drops CYC after its first ack with reads outstanding
      stall_ws = 0; ack_ws = 3;
      m_cyc = 2'b11; m_stb = 2'b01; m_we = 2'b00;
      m_addr[0 +: AW] = 6'd8;
      issued = 0; t = 0; got = 1'b0;
      while (!got && t < 50) begin
         @(negedge clk);
         acc = m_stb[0] && !m_stall[0];
         got = m_ack[0];
         @(posedge clk); #1;
         t++;
         if (acc) begin
            issued++;
            if (issued == 4) m_stb[0] = 1'b0;
            else m_addr[0 +: AW] = AW'(8 + issued);
         end
      end
      check("abort_first_ack", 64'(got), 64'd1);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; tb_ack = 1'b1;
      @(negedge clk);
      check("abort_same_cycle", {s_cyc, m_ack, m_stall[1], gv, gi}, 6'b0_00_1_1_0);
      @(posedge clk); #1;
      tb_ack = 1'b0;
      @(negedge clk);
      check("abort_m1_granted", {s_cyc, m_ack, gv, gi}, 5'b1_00_1_1);
      any_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_ack !== 2'b00) any_ack = 1'b1;
      end
      check("abort_no_late_ack", 64'(any_ack), 64'd0);
      @(posedge clk); #1;
      m_cyc = '0;
      @(posedge clk); #1;

      // asynchronous reset during master 0's grant
      m_cyc = 2'b11;
      @(posedge clk); #1;
      tb_ack = 1'b1;
      @(negedge clk);
      check("rst_pre_grant", {s_cyc, m_ack, gv, gi}, 5'b1_01_1_0);
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_drop", {s_cyc, gv, m_ack}, 4'b0_0_00);
      m_cyc = '0; tb_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      m_cyc = 2'b11;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_m0_first", {gv, gi}, 2'b1_0);
      @(posedge clk); #1;
      m_cyc = '0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
